except_ctrl: RTL and testbench
==============================

Name: except_ctrl

Overview:
- MEM-stage exception/interrupt initiator for the CP0 block.
- Merges per-instruction exception info with masked interrupts and selects one winner per cycle.
- Drives the registered except_req_t request into CP0.
- Issues a one-cycle pipeline flush plus a redirect PC (exception vector, or EPC/ErrorEPC for ERET).
- A holdoff window covers the cycles before CP0's latched Status.EXL becomes visible.

Parameters:
- HOLDOFF_CYCLES, 2, cycles after an issued request during which MEM inputs and interrupts are ignored.
- BEV_BASE, 32'hBFC00200, vector base used when Status.BEV=1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_delayed_mispredict  in  1  kills a registered, not-yet-consumed request
- mem_valid  in  1  a valid instruction occupies MEM
- mem_pc  in  32  PC of the MEM instruction
- mem_delayslot  in  1  MEM instruction is in a branch delay slot
- mem_exc_valid  in  1  MEM instruction raised a synchronous exception
- mem_exc_code  in  5  ExcCode of that exception
- mem_exc_extra  in  32  bad vaddr (AdEL/AdES/TLB*) or CE in [1:0] (CpU)
- mem_tlb_refill  in  1  the TLB exception is a refill (no matching entry)
- mem_eret  in  1  MEM instruction is ERET
- cp0_regs  in  cp0_regs_t  current CP0 register file
- interrupt_flag  in  8  hardware interrupt lines; [7:2] are used
- except_req  out  except_req_t  request to CP0 (valid, eret, delayslot, code, extra, pc)
- flush  out  1  flush IF..MEM
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  fetch target

Behaviour:
- Reset: except_req = '0; flush = 0; redirect_valid = 0; redirect_pc = 0; holdoff counter = 0; state = IDLE.
- Interrupt pending: int_pend = ({interrupt_flag[7:2], cp0_regs.cause.ip[1:0]} & cp0_regs.status.im) != 0.
- Interrupt taken only if: pending, status.ie = 1, exl = 0, erl = 0, mem_valid = 1, and state IDLE.
- Priority per cycle: interrupt > mem_exc_valid > mem_eret.
  - Interrupt: code EXCCODE_INT, extra = 0, pc = mem_pc, delayslot = mem_delayslot.
  - mem_exc_valid without mem_valid is ignored.
- Vector: base = status.bev ? BEV_BASE : {cp0_regs.ebase[31:12], 12'h000}.
  - Offset 0x180 by default.
  - Offset 0x200 for an interrupt with cause.iv = 1 and bev = 0.
- ERET: redirect_pc = erl ? error_epc : epc; except_req.eret = 1.
- Latency: the decision is combinational in cycle N; outputs are registered and visible in cycle N+1.
  - flush and redirect_valid are single-cycle pulses.
  - except_req.valid is a single-cycle pulse.
  - redirect_pc holds its value until the next issue.
- State machine:
  - IDLE: an issue loads HOLDOFF_CYCLES into the counter, then go to HOLD.
  - HOLD: all MEM inputs and interrupts are ignored; decrement each cycle; at 1, go to IDLE.
  - HOLDOFF_CYCLES = 0: the FSM never enters HOLD.
- flush_delayed_mispredict in the cycle after an issue clears except_req.valid, flush and redirect_valid before they are sampled; the holdoff still runs.
- Same-cycle interrupt plus ERET: the interrupt wins; EPC = ERET's own PC; the ERET re-executes after the handler.
- Reset mid-HOLD: FSM returns to IDLE; counter = 0; outputs cleared the next cycle.
- Outputs are idle while the counter is nonzero, even if the inputs stay asserted.

Optional Feature:
- Macro: EXC_TLB_REFILL_VEC_EN.
- Defined: code TLBL/TLBS with mem_tlb_refill = 1 and exl = 0 uses offset 0x000; with exl = 1 it uses 0x180.
- Undefined: mem_tlb_refill is ignored and all TLB exceptions use 0x180.

Decomposition:
- Shared package (cpu_defs):
  - except_req_t, cp0_regs_t, EXCCODE_* constants.
  - Vector offsets: EXC_OFS_REFILL = 0x000, EXC_OFS_GENERAL = 0x180, EXC_OFS_INT = 0x200.
- One sub-module, except_vector_sel: purely combinational base/offset/EPC selection, separated to allow reuse by a future debug unit.
- FSM, counter and priority logic stay in except_ctrl.

Test Plan:
- Interrupt: bev = 0, ebase = 0x80000000, ie = 1, im = 0x80, interrupt_flag = 0x80, mem_pc = 0x80001000 → next cycle except_req.valid = 1, code = INT, pc = 0x80001000; redirect_pc = 0x80000180; flush pulse of 1 cycle.
- AdEL in a delay slot: mem_pc = 0x80002004, extra = 0x00000003, bev = 1 → except_req.delayslot = 1, extra = 0x3; redirect_pc = 0xBFC00380.
- ERET: erl = 0, epc = 0x80003000 → except_req.eret = 1; redirect_pc = 0x80003000.
- Holdoff: issue, then an interrupt plus mem_exc_valid held for 2 cycles → no second request until cycle 3 after the issue.
- Refill, macro on: TLBL with mem_tlb_refill = 1, exl = 0 → redirect_pc = 0x80000000. Same stimulus with the macro off → 0x80000180.
- Kill and reset: flush_delayed_mispredict in the cycle after an issue → except_req.valid = 0. rst asserted in HOLD → all outputs 0 and a new interrupt is accepted 1 cycle after reset deasserts.

Source files
------------

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared CP0 / exception definitions: ExcCode constants, exception vector
// offsets, the CP0 register view (cp0_regs_t), the MEM-stage request into
// CP0 (except_req_t), the except_ctrl FSM state type and a TLB-code helper.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package cpu_defs;

    // MIPS32 ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_MOD  = 5'd1;
    localparam logic [4:0] EXCCODE_TLBL = 5'd2;
    localparam logic [4:0] EXCCODE_TLBS = 5'd3;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_CPU  = 5'd11;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    // Offsets added to the vector base
    localparam logic [11:0] EXC_OFS_REFILL  = 12'h000;
    localparam logic [11:0] EXC_OFS_GENERAL = 12'h180;
    localparam logic [11:0] EXC_OFS_INT     = 12'h200;

    typedef struct packed {
        logic       bev;
        logic [7:0] im;
        logic       erl;
        logic       exl;
        logic       ie;
    } cp0_status_t;

    typedef struct packed {
        logic       bd;
        logic       iv;
        logic [7:0] ip;        // [1:0] are the software interrupt bits
        logic [4:0] exc_code;
    } cp0_cause_t;

    typedef struct packed {
        cp0_status_t status;
        cp0_cause_t  cause;
        logic [31:0] epc;
        logic [31:0] error_epc;
        logic [31:0] ebase;
    } cp0_regs_t;

    typedef struct packed {
        logic        valid;
        logic        eret;
        logic        delayslot;
        logic [4:0]  code;
        logic [31:0] extra;
        logic [31:0] pc;
    } except_req_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ctrl_state_t;

    function automatic logic is_tlb_code(input logic [4:0] code);
        return (code == EXCCODE_TLBL) || (code == EXCCODE_TLBS);
    endfunction

endpackage

// File: rtl/except_vector_sel.sv
// ---------------------------------------------------------------------------
// except_vector_sel
// Purely combinational redirect-target selection: vector base (BEV or EBase),
// vector offset (general / interrupt / TLB refill) and EPC vs ErrorEPC for
// ERET. Kept separate so a debug unit can reuse the same selection.
//
// Optional feature: EXC_TLB_REFILL_VEC_EN
//   defined   - a TLB refill (TLBL/TLBS, no matching entry, EXL=0) uses the
//               refill offset 0x000
//   undefined - refill indication is ignored; all TLB exceptions use 0x180
//
// Ports:
//   i_bev, i_iv, i_exl, i_erl  CP0 Status/Cause bits
//   i_ebase_hi                 EBase[31:12]
//   i_epc, i_error_epc         ERET return targets
//   i_is_int                   the winner is an interrupt
//   i_is_eret                  the winner is an ERET
//   i_exc_code                 ExcCode of the winning synchronous exception
//   i_tlb_refill               winner is a synchronous exception with refill set
//   o_vec_pc                   fetch redirect target
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module except_vector_sel
    import cpu_defs::*;
#(
    parameter logic [31:0] BEV_BASE = 32'hBFC00200
) (
    input  logic        i_bev,
    input  logic        i_iv,
    input  logic        i_exl,
    input  logic        i_erl,
    input  logic [19:0] i_ebase_hi,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_error_epc,
    input  logic        i_is_int,
    input  logic        i_is_eret,
    input  logic [4:0]  i_exc_code,
    input  logic        i_tlb_refill,
    output logic [31:0] o_vec_pc
);

    logic [31:0] w_base;
    logic [11:0] w_ofs;
    logic        w_refill;

`ifdef EXC_TLB_REFILL_VEC_EN
    // A nested TLB miss (EXL already set) goes through the general vector.
    assign w_refill = i_tlb_refill & ~i_exl & is_tlb_code(i_exc_code);
`else
    logic w_unused;
    assign w_refill = 1'b0;
    assign w_unused = ^{i_tlb_refill, i_exl, i_exc_code};
`endif

    assign w_base = i_bev ? BEV_BASE : {i_ebase_hi, 12'h000};

    always_comb begin
        w_ofs = EXC_OFS_GENERAL;
        if (i_is_int && i_iv && !i_bev)
            w_ofs = EXC_OFS_INT;
        else if (w_refill)
            w_ofs = EXC_OFS_REFILL;
    end

    // BEV base is not 4K aligned (0xBFC00200), so the offset is added.
    assign o_vec_pc = i_is_eret ? (i_erl ? i_error_epc : i_epc)
                                : (w_base + {20'h0, w_ofs});

endmodule

// File: rtl/except_ctrl.sv
// ---------------------------------------------------------------------------
// except_ctrl
// MEM-stage exception/interrupt initiator. Each cycle it picks one winner
// (interrupt > synchronous exception > ERET), registers the request into CP0,
// pulses flush/redirect for one cycle and holds the redirect PC. After an
// issue a holdoff window of HOLDOFF_CYCLES ignores MEM and interrupts until
// CP0's updated Status.EXL becomes visible.
//
// Optional feature: EXC_TLB_REFILL_VEC_EN (TLB refill vector, see
// except_vector_sel).
//
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_flush_delayed_mispredict     kills a registered, not-yet-consumed request
//   i_mem_*                        MEM-stage instruction and exception info
//   i_cp0_regs                     current CP0 register view
//   i_interrupt_flag               hardware interrupt lines ([7:2] used)
//   o_except_req                   registered request to CP0
//   o_flush                        one-cycle flush of IF..MEM
//   o_redirect_valid, o_redirect_pc fetch redirect strobe / held target
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module except_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 2,
    parameter logic [31:0] BEV_BASE       = 32'hBFC00200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush_delayed_mispredict,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_pc,
    input  logic        i_mem_delayslot,
    input  logic        i_mem_exc_valid,
    input  logic [4:0]  i_mem_exc_code,
    input  logic [31:0] i_mem_exc_extra,
    input  logic        i_mem_tlb_refill,
    input  logic        i_mem_eret,
    input  cp0_regs_t   i_cp0_regs,
    input  logic [7:0]  i_interrupt_flag,
    output except_req_t o_except_req,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc
);

    localparam int unsigned      CNT_W     = $clog2(HOLDOFF_CYCLES + 2);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ctrl_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    except_req_t r_req, w_req_nxt;
    logic        r_flush, r_redirect_valid;
    logic [31:0] r_redirect_pc, w_vec_pc;

    logic w_idle, w_int_pend, w_take_int, w_take_exc, w_take_eret, w_issue;
    logic w_unused;

    // ---------------- priority / winner selection ----------------
    assign w_idle     = (r_state == ST_IDLE);
    assign w_int_pend = |({i_interrupt_flag[7:2], i_cp0_regs.cause.ip[1:0]}
                          & i_cp0_regs.status.im);

    assign w_take_int  = w_int_pend & i_cp0_regs.status.ie & ~i_cp0_regs.status.exl
                       & ~i_cp0_regs.status.erl & i_mem_valid & w_idle;
    assign w_take_exc  = ~w_take_int & i_mem_valid & i_mem_exc_valid & w_idle;
    assign w_take_eret = ~w_take_int & ~w_take_exc & i_mem_valid & i_mem_eret & w_idle;
    assign w_issue     = w_take_int | w_take_exc | w_take_eret;

    except_vector_sel #(
        .BEV_BASE (BEV_BASE)
    ) u_vec_sel (
        .i_bev        (i_cp0_regs.status.bev),
        .i_iv         (i_cp0_regs.cause.iv),
        .i_exl        (i_cp0_regs.status.exl),
        .i_erl        (i_cp0_regs.status.erl),
        .i_ebase_hi   (i_cp0_regs.ebase[31:12]),
        .i_epc        (i_cp0_regs.epc),
        .i_error_epc  (i_cp0_regs.error_epc),
        .i_is_int     (w_take_int),
        .i_is_eret    (w_take_eret),
        .i_exc_code   (i_mem_exc_code),
        .i_tlb_refill (w_take_exc & i_mem_tlb_refill),
        .o_vec_pc     (w_vec_pc)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                // With a zero holdoff the FSM stays in IDLE.
                if (w_issue && (HOLDOFF_CYCLES != 0)) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs (next values) ----------------
    always_comb begin
        w_req_nxt = '0;
        if (w_issue) begin
            w_req_nxt.valid     = 1'b1;
            w_req_nxt.eret      = w_take_eret;
            w_req_nxt.delayslot = i_mem_delayslot;
            w_req_nxt.code      = w_take_exc ? i_mem_exc_code : EXCCODE_INT;
            w_req_nxt.extra     = w_take_exc ? i_mem_exc_extra : 32'h0;
            w_req_nxt.pc        = i_mem_pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req            <= '0;
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'h0;
        end else begin
            r_req            <= w_req_nxt;
            r_flush          <= w_issue;
            r_redirect_valid <= w_issue;
            if (w_issue)
                r_redirect_pc <= w_vec_pc;
        end
    end

    // A delayed mispredict flush kills the pending request before CP0 and
    // fetch sample it; the holdoff window is left running.
    always_comb begin
        o_except_req       = r_req;
        o_except_req.valid = r_req.valid & ~i_flush_delayed_mispredict;
    end

    assign o_flush          = r_flush & ~i_flush_delayed_mispredict;
    assign o_redirect_valid = r_redirect_valid & ~i_flush_delayed_mispredict;
    assign o_redirect_pc    = r_redirect_pc;

    assign w_unused = ^{i_interrupt_flag[1:0], i_cp0_regs.cause.bd,
                        i_cp0_regs.cause.ip[7:2], i_cp0_regs.cause.exc_code,
                        i_cp0_regs.ebase[11:0]};

endmodule

// File: tb/tb_except_ctrl.sv
`timescale 1ns/1ps
module tb_except_ctrl;
    import cpu_defs::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush_delayed_mispredict;
    logic        i_mem_valid;
    logic [31:0] i_mem_pc;
    logic        i_mem_delayslot;
    logic        i_mem_exc_valid;
    logic [4:0]  i_mem_exc_code;
    logic [31:0] i_mem_exc_extra;
    logic        i_mem_tlb_refill;
    logic        i_mem_eret;
    cp0_regs_t   i_cp0_regs;
    logic [7:0]  i_interrupt_flag;
    except_req_t o_except_req;
    logic        o_flush;
    logic        o_redirect_valid;
    logic [31:0] o_redirect_pc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    except_ctrl dut (
        .i_clk                      (i_clk),
        .i_rst                      (i_rst),
        .i_flush_delayed_mispredict (i_flush_delayed_mispredict),
        .i_mem_valid                (i_mem_valid),
        .i_mem_pc                   (i_mem_pc),
        .i_mem_delayslot            (i_mem_delayslot),
        .i_mem_exc_valid            (i_mem_exc_valid),
        .i_mem_exc_code             (i_mem_exc_code),
        .i_mem_exc_extra            (i_mem_exc_extra),
        .i_mem_tlb_refill           (i_mem_tlb_refill),
        .i_mem_eret                 (i_mem_eret),
        .i_cp0_regs                 (i_cp0_regs),
        .i_interrupt_flag           (i_interrupt_flag),
        .o_except_req               (o_except_req),
        .o_flush                    (o_flush),
        .o_redirect_valid           (o_redirect_valid),
        .o_redirect_pc              (o_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // inputs change 1ns after the edge; registered outputs read 1ns after the next edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_mem();
        i_mem_valid      = 1'b0;
        i_mem_pc         = 32'h0;
        i_mem_delayslot  = 1'b0;
        i_mem_exc_valid  = 1'b0;
        i_mem_exc_code   = 5'd0;
        i_mem_exc_extra  = 32'h0;
        i_mem_tlb_refill = 1'b0;
        i_mem_eret       = 1'b0;
        i_interrupt_flag = 8'h0;
    endtask

    // quiet cycles long enough to clear a 2-cycle holdoff
    task automatic settle();
        clr_mem();
        tick();
        tick();
        tick();
    endtask

    task automatic irq_at(input logic [31:0] pc);
        i_mem_valid      = 1'b1;
        i_mem_pc         = pc;
        i_interrupt_flag = 8'h80;
    endtask

    initial begin
        i_rst = 1'b1;
        i_flush_delayed_mispredict = 1'b0;
        clr_mem();
        i_cp0_regs               = '0;
        i_cp0_regs.status.ie     = 1'b1;
        i_cp0_regs.status.im     = 8'h80;
        i_cp0_regs.ebase         = 32'h8000_0000;
        i_cp0_regs.epc           = 32'h8000_3000;
        i_cp0_regs.error_epc     = 32'h8000_4000;
        tick();
        tick();

        // reset state
        chk("rst_valid", 32'(o_except_req.valid), 32'h0);
        chk("rst_flush", 32'(o_flush), 32'h0);
        chk("rst_redir_v", 32'(o_redirect_valid), 32'h0);
        chk("rst_redir_pc", o_redirect_pc, 32'h0);
        i_rst = 1'b0;
        tick();

        // interrupt, BEV=0, EBase 0x80000000
        irq_at(32'h8000_1000);
        tick();
        chk("int_valid", 32'(o_except_req.valid), 32'h1);
        chk("int_code", 32'(o_except_req.code), 32'(EXCCODE_INT));
        chk("int_pc", o_except_req.pc, 32'h8000_1000);
        chk("int_extra", o_except_req.extra, 32'h0);
        chk("int_redir_pc", o_redirect_pc, 32'h8000_0180);
        chk("int_flush", 32'(o_flush), 32'h1);
        chk("int_redir_v", 32'(o_redirect_valid), 32'h1);
        clr_mem();
        tick();
        chk("int_flush_pulse", 32'(o_flush), 32'h0);
        chk("int_valid_pulse", 32'(o_except_req.valid), 32'h0);
        chk("int_redir_hold", o_redirect_pc, 32'h8000_0180);
        tick();
        tick();

        // exception without a valid instruction is ignored
        i_mem_exc_valid = 1'b1;
        i_mem_exc_code  = EXCCODE_RI;
        tick();
        chk("novalid_exc", 32'(o_except_req.valid), 32'h0);
        clr_mem();

        // AdEL in a delay slot, BEV=1
        i_cp0_regs.status.bev = 1'b1;
        i_mem_valid     = 1'b1;
        i_mem_pc        = 32'h8000_2004;
        i_mem_delayslot = 1'b1;
        i_mem_exc_valid = 1'b1;
        i_mem_exc_code  = EXCCODE_ADEL;
        i_mem_exc_extra = 32'h0000_0003;
        tick();
        chk("adel_valid", 32'(o_except_req.valid), 32'h1);
        chk("adel_ds", 32'(o_except_req.delayslot), 32'h1);
        chk("adel_code", 32'(o_except_req.code), 32'(EXCCODE_ADEL));
        chk("adel_extra", o_except_req.extra, 32'h3);
        chk("adel_eret", 32'(o_except_req.eret), 32'h0);
        chk("adel_redir_pc", o_redirect_pc, 32'hBFC0_0380);
        i_cp0_regs.status.bev = 1'b0;
        settle();

        // ERET with ERL=0 -> EPC
        i_mem_valid = 1'b1;
        i_mem_pc    = 32'h8000_2100;
        i_mem_eret  = 1'b1;
        tick();
        chk("eret_valid", 32'(o_except_req.valid), 32'h1);
        chk("eret_flag", 32'(o_except_req.eret), 32'h1);
        chk("eret_redir_pc", o_redirect_pc, 32'h8000_3000);
        settle();

        // ERET with ERL=1 -> ErrorEPC
        i_cp0_regs.status.erl = 1'b1;
        i_mem_valid = 1'b1;
        i_mem_pc    = 32'h8000_2200;
        i_mem_eret  = 1'b1;
        tick();
        chk("eret_erl_redir", o_redirect_pc, 32'h8000_4000);
        i_cp0_regs.status.erl = 1'b0;
        settle();

        // holdoff: interrupt + exception held asserted across the window
        irq_at(32'h8000_1100);
        i_mem_exc_valid = 1'b1;
        i_mem_exc_code  = EXCCODE_OV;
        tick();
        chk("hold_first", 32'(o_except_req.valid), 32'h1);
        tick();
        chk("hold_c1_valid", 32'(o_except_req.valid), 32'h0);
        chk("hold_c1_flush", 32'(o_flush), 32'h0);
        tick();
        chk("hold_c2_valid", 32'(o_except_req.valid), 32'h0);
        tick();
        chk("hold_c3_valid", 32'(o_except_req.valid), 32'h1);
        chk("hold_c3_code", 32'(o_except_req.code), 32'(EXCCODE_INT));
        settle();

        // interrupt and ERET in the same cycle: interrupt wins
        irq_at(32'h8000_5000);
        i_mem_eret = 1'b1;
        tick();
        chk("inteq_code", 32'(o_except_req.code), 32'(EXCCODE_INT));
        chk("inteq_eret", 32'(o_except_req.eret), 32'h0);
        chk("inteq_pc", o_except_req.pc, 32'h8000_5000);
        chk("inteq_redir", o_redirect_pc, 32'h8000_0180);
        settle();

        // interrupt with Cause.IV=1 -> offset 0x200
        i_cp0_regs.cause.iv = 1'b1;
        irq_at(32'h8000_5100);
        tick();
        chk("iv_redir", o_redirect_pc, 32'h8000_0200);
        i_cp0_regs.cause.iv = 1'b0;
        settle();

        // TLBL refill, EXL=0
        i_mem_valid      = 1'b1;
        i_mem_pc         = 32'h8000_6000;
        i_mem_exc_valid  = 1'b1;
        i_mem_exc_code   = EXCCODE_TLBL;
        i_mem_exc_extra  = 32'h0040_0000;
        i_mem_tlb_refill = 1'b1;
        tick();
`ifdef EXC_TLB_REFILL_VEC_EN
        chk("refill_redir", o_redirect_pc, 32'h8000_0000);
`else
        chk("refill_redir", o_redirect_pc, 32'h8000_0180);
`endif
        chk("refill_extra", o_except_req.extra, 32'h0040_0000);
        settle();

        // TLBL refill, EXL=1 -> general vector
        i_cp0_regs.status.exl = 1'b1;
        i_mem_valid      = 1'b1;
        i_mem_pc         = 32'h8000_6004;
        i_mem_exc_valid  = 1'b1;
        i_mem_exc_code   = EXCCODE_TLBL;
        i_mem_tlb_refill = 1'b1;
        tick();
        chk("refill_exl_redir", o_redirect_pc, 32'h8000_0180);
        i_cp0_regs.status.exl = 1'b0;
        settle();

        // delayed mispredict kills the registered request
        irq_at(32'h8000_7000);
        tick();
        i_flush_delayed_mispredict = 1'b1;
        #1;
        chk("kill_valid", 32'(o_except_req.valid), 32'h0);
        chk("kill_flush", 32'(o_flush), 32'h0);
        chk("kill_redir_v", 32'(o_redirect_valid), 32'h0);
        i_flush_delayed_mispredict = 1'b0;
        tick();
        chk("kill_holdoff", 32'(o_except_req.valid), 32'h0);
        settle();

        // reset during HOLD, then an interrupt right after release
        irq_at(32'h8000_8000);
        tick();
        chk("rsth_issue", 32'(o_except_req.valid), 32'h1);
        i_rst = 1'b1;
        tick();
        chk("rsth_valid", 32'(o_except_req.valid), 32'h0);
        chk("rsth_flush", 32'(o_flush), 32'h0);
        chk("rsth_redir_v", 32'(o_redirect_valid), 32'h0);
        chk("rsth_redir_pc", o_redirect_pc, 32'h0);
        i_rst = 1'b0;
        tick();
        chk("rsth_accept", 32'(o_except_req.valid), 32'h1);
        chk("rsth_accept_pc", o_except_req.pc, 32'h8000_8000);
        settle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
